// File: rtl/mem_lsu_pkg.sv
// Shared pipeline definitions: datapath widths, load/store type codes and
// the LSU state encoding, plus small classification helpers.
package mem_lsu_pkg;

    localparam int XLEN = 32;
    localparam int BE_W = XLEN / 8;

    typedef enum logic [3:0] {
        SL_NONE = 4'd0,
        SL_LB   = 4'd1,
        SL_LH   = 4'd2,
        SL_LW   = 4'd3,
        SL_LBU  = 4'd4,
        SL_LHU  = 4'd5,
        SL_SB   = 4'd6,
        SL_SH   = 4'd7,
        SL_SW   = 4'd8
    } sl_type_t;

    typedef enum logic [1:0] {
        S_IDLE        = 2'd0,
        S_WAIT_GNT    = 2'd1,
        S_WAIT_RVALID = 2'd2,
        S_DONE        = 2'd3
    } lsu_state_t;

    function automatic logic is_load_type(input logic [3:0] t);
        return (t == SL_LB) || (t == SL_LH) || (t == SL_LW) ||
               (t == SL_LBU) || (t == SL_LHU);
    endfunction

    function automatic logic is_store_type(input logic [3:0] t);
        return (t == SL_SB) || (t == SL_SH) || (t == SL_SW);
    endfunction

    // Codes 9-15 fall through every test here and so behave as NONE.
    function automatic logic misaligned_access(input logic [3:0] t, input logic [1:0] off);
        logic half, word;
        half = (t == SL_LH) || (t == SL_LHU) || (t == SL_SH);
        word = (t == SL_LW) || (t == SL_SW);
        return (half && off[0]) || (word && (off != 2'b00));
    endfunction

endpackage

// File: rtl/mem_lsu_load_extend.sv
// Picks the addressed byte/half/word out of a read beat and sign- or
// zero-extends it according to the load type.
module load_extend
    import mem_lsu_pkg::*;
(
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      offset,
    input  logic [3:0]      sl_type,
    output logic [XLEN-1:0] data
);

    logic [XLEN-1:0] shifted;

    assign shifted = rdata >> {offset, 3'b000};

    always_comb begin
        data = rdata;
        case (sl_type)
            SL_LB:   data = {{24{shifted[7]}}, shifted[7:0]};
            SL_LH:   data = {{16{shifted[15]}}, shifted[15:0]};
            SL_LBU:  data = {24'd0, shifted[7:0]};
            SL_LHU:  data = {16'd0, shifted[15:0]};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: one outstanding data-memory access at a time,
// stalling the pipeline until the grant (and, for loads, the read data) arrives.
module mem_lsu
    import mem_lsu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            instr_valid_mem_i,
    input  logic            dram_we_mem_i,
    input  logic [XLEN-1:0] alu_result_mem_i,
    input  logic [XLEN-1:0] rD2_mem_i,
    input  logic [3:0]      sl_type_mem_i,
    output logic            dmem_req_o,
    output logic            dmem_we_o,
    output logic [XLEN-1:0] dmem_addr_o,
    output logic [BE_W-1:0] dmem_be_o,
    output logic [XLEN-1:0] dmem_wdata_o,
    input  logic            dmem_gnt_i,
    input  logic            dmem_rvalid_i,
    input  logic [XLEN-1:0] dmem_rdata_i,
    output logic            stall_o,
    output logic [XLEN-1:0] load_data_o,
    output logic            load_valid_o,
    output logic            misalign_o,
    output lsu_state_t      state_o
);

    // Bus handshake: a beat transfers in the cycle where dmem_req_o and
    // dmem_gnt_i are both high; dmem_req_o, once raised, stays high with
    // stable fields until granted. Read data transfers on dmem_rvalid_i.

    lsu_state_t      state, state_next;
    logic            is_load, is_store, is_misaligned, new_op;
    logic [XLEN-1:0] new_addr, new_wdata;
    logic [BE_W-1:0] new_be;
    logic [XLEN-1:0] addr_q, wdata_q, load_data_q, ext_data;
    logic [BE_W-1:0] be_q;
    logic            we_q;
    logic [3:0]      type_q;
    logic [1:0]      off_q;

    assign is_load       = instr_valid_mem_i && !dram_we_mem_i && is_load_type(sl_type_mem_i);
    assign is_store      = instr_valid_mem_i && dram_we_mem_i && is_store_type(sl_type_mem_i);
    assign is_misaligned = misaligned_access(sl_type_mem_i, alu_result_mem_i[1:0]);
    assign new_op        = !rst && (state == S_IDLE) && (is_load || is_store) && !is_misaligned;
    assign new_addr      = {alu_result_mem_i[XLEN-1:2], 2'b00};
    assign state_o       = state;

    always_comb begin
        new_be    = 4'b1111;
        new_wdata = rD2_mem_i;
        if (is_store) begin
            case (sl_type_mem_i)
                SL_SB: begin
                    new_be    = 4'b0001 << alu_result_mem_i[1:0];
                    new_wdata = {4{rD2_mem_i[7:0]}};
                end
                SL_SH: begin
                    new_be    = alu_result_mem_i[1] ? 4'b1100 : 4'b0011;
                    new_wdata = {2{rD2_mem_i[15:0]}};
                end
                default: ;
            endcase
        end
    end

    load_extend u_load_extend (
        .rdata   (dmem_rdata_i),
        .offset  (off_q),
        .sl_type (type_q),
        .data    (ext_data)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q      <= '0;
            be_q        <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            type_q      <= '0;
            off_q       <= '0;
            load_data_q <= '0;
        end else begin
            if (new_op) begin
                addr_q  <= new_addr;
                be_q    <= new_be;
                wdata_q <= new_wdata;
                we_q    <= is_store;
                type_q  <= sl_type_mem_i;
                off_q   <= alu_result_mem_i[1:0];
            end
            if ((state == S_WAIT_RVALID) && dmem_rvalid_i) load_data_q <= ext_data;
        end
    end

    always_comb begin
        state_next   = state;
        dmem_req_o   = 1'b0;
        dmem_we_o    = 1'b0;
        stall_o      = 1'b0;
        load_valid_o = 1'b0;
        misalign_o   = 1'b0;
        case (state)
            S_IDLE: begin
                misalign_o = (is_load || is_store) && is_misaligned;
                if (new_op) begin
                    dmem_req_o = 1'b1;
                    dmem_we_o  = is_store;
                    stall_o    = !dmem_gnt_i || is_load;
                    if (!dmem_gnt_i) state_next = S_WAIT_GNT;
                    else if (is_load) state_next = S_WAIT_RVALID;
                end
            end
            S_WAIT_GNT: begin
                dmem_req_o = 1'b1;
                dmem_we_o  = we_q;
                stall_o    = 1'b1;
                if (dmem_gnt_i) state_next = we_q ? S_IDLE : S_WAIT_RVALID;
            end
            S_WAIT_RVALID: begin
                stall_o = 1'b1;
                if (dmem_rvalid_i) state_next = S_DONE;
            end
            S_DONE: begin
                load_valid_o = 1'b1;
                state_next   = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
        // While reset is held every output is forced quiet, even before the
        // first reset edge has cleared the registers.
        if (rst) begin
            dmem_req_o   = 1'b0;
            dmem_we_o    = 1'b0;
            stall_o      = 1'b0;
            load_valid_o = 1'b0;
            misalign_o   = 1'b0;
        end
    end

    always_comb begin
        dmem_addr_o  = new_op ? new_addr  : addr_q;
        dmem_be_o    = new_op ? new_be    : be_q;
        dmem_wdata_o = new_op ? new_wdata : wdata_q;
        load_data_o  = load_data_q;
        if (rst) begin
            dmem_addr_o  = '0;
            dmem_be_o    = '0;
            dmem_wdata_o = '0;
            load_data_o  = '0;
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: directed cases for the headline scenarios, then random
// load/store/no-op traffic checked against a behavioural model through queues.
module tb_mem_lsu;
    import mem_lsu_pkg::*;

    localparam logic [3:0] T_NONE = 4'd0, T_LB = 4'd1, T_LH = 4'd2, T_LW = 4'd3,
                           T_LBU = 4'd4, T_LHU = 4'd5, T_SB = 4'd6, T_SH = 4'd7, T_SW = 4'd8;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid, dram_we;
    logic [31:0] alu_result, rd2;
    logic [3:0]  sl_type;
    logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        stall, load_valid, misalign;
    logic [31:0] load_data;
    lsu_state_t  state;

    int checks = 0;
    int failures = 0;

    bus_t        bus_q[$];
    logic [31:0] exp_q[$];

    logic        prev_wait = 1'b0;
    bus_t        prev_bus;

    mem_lsu dut (
        .clk               (clk),
        .rst               (rst),
        .instr_valid_mem_i (instr_valid),
        .dram_we_mem_i     (dram_we),
        .alu_result_mem_i  (alu_result),
        .rD2_mem_i         (rd2),
        .sl_type_mem_i     (sl_type),
        .dmem_req_o        (dmem_req),
        .dmem_we_o         (dmem_we),
        .dmem_addr_o       (dmem_addr),
        .dmem_be_o         (dmem_be),
        .dmem_wdata_o      (dmem_wdata),
        .dmem_gnt_i        (dmem_gnt),
        .dmem_rvalid_i     (dmem_rvalid),
        .dmem_rdata_i      (dmem_rdata),
        .stall_o           (stall),
        .load_data_o       (load_data),
        .load_valid_o      (load_valid),
        .misalign_o        (misalign),
        .state_o           (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit m_is_load(input logic v, input logic we, input logic [3:0] t);
        return v && !we && (t >= T_LB) && (t <= T_LHU);
    endfunction

    function automatic bit m_is_store(input logic v, input logic we, input logic [3:0] t);
        return v && we && (t >= T_SB) && (t <= T_SW);
    endfunction

    function automatic bit m_misaligned(input logic [3:0] t, input logic [31:0] a);
        int size;
        size = 1;
        if (t == T_LH || t == T_LHU || t == T_SH) size = 2;
        if (t == T_LW || t == T_SW) size = 4;
        return (a % size) != 0;
    endfunction

    function automatic bus_t m_bus(input bit st, input logic [3:0] t, input logic [31:0] a,
                                   input logic [31:0] d);
        bus_t e;
        int   off;
        off     = int'(a % 4);
        e.we    = st;
        e.addr  = a - (a % 4);
        e.be    = 4'hF;
        e.wdata = d;
        if (st && t == T_SB) begin
            e.be    = 4'(1 << off);
            e.wdata = (d % 256) * 32'h0101_0101;
        end else if (st && t == T_SH) begin
            e.be    = (off >= 2) ? 4'b1100 : 4'b0011;
            e.wdata = (d % 65536) * 32'h0001_0001;
        end
        return e;
    endfunction

    function automatic logic [31:0] m_load(input logic [3:0] t, input logic [31:0] a,
                                           input logic [31:0] r);
        logic [31:0] v;
        v = r >> (8 * int'(a % 4));
        case (t)
            T_LB:  begin v = v % 256;   if (v >= 128)   v = v - 256;   end
            T_LH:  begin v = v % 65536; if (v >= 32768) v = v - 65536; end
            T_LBU: v = v % 256;
            T_LHU: v = v % 65536;
            default: v = r;
        endcase
        return v;
    endfunction

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        instr_valid = 1'b0;
        dram_we     = 1'b0;
        sl_type     = T_NONE;
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
    endtask

    // gd: cycles the grant is withheld; rd: cycles between grant and rvalid.
    task automatic do_op(input logic v, input logic we, input logic [3:0] t, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] r, input int gd, input int rd);
        bit ld, st, mis;
        int stalls, exp_stalls;
        ld     = m_is_load(v, we, t);
        st     = m_is_store(v, we, t);
        mis    = (ld || st) && m_misaligned(t, a);
        stalls = 0;
        tick();
        instr_valid = v;
        dram_we     = we;
        alu_result  = a;
        rd2         = d;
        sl_type     = t;
        dmem_gnt    = (gd == 0);
        dmem_rvalid = 1'($urandom_range(0, 1));
        dmem_rdata  = $urandom;
        if ((ld || st) && !mis) bus_q.push_back(m_bus(st, t, a, d));
        #3;
        chk("misalign_pulse", misalign, mis);
        if (!(ld || st) || mis) chk("no_request", dmem_req, 1'b0);
        stalls += int'(stall);
        if ((ld || st) && !mis) begin
            for (int i = 0; i < gd; i++) begin
                tick();
                instr_valid = 1'b0;
                dmem_gnt    = (i == gd - 1);
                dmem_rvalid = 1'($urandom_range(0, 1));
                #3;
                stalls += int'(stall);
            end
            if (ld) begin
                for (int i = 0; i <= rd; i++) begin
                    tick();
                    instr_valid = 1'b0;
                    dmem_gnt    = 1'($urandom_range(0, 1));
                    dmem_rvalid = (i == rd);
                    dmem_rdata  = (i == rd) ? r : $urandom;
                    #3;
                    stalls += int'(stall);
                end
                exp_q.push_back(m_load(t, a, r));
                tick();
                idle_inputs();
                #3;
                chk("load_valid_latency", load_valid, 1'b1);
                stalls += int'(stall);
            end
        end
        tick();
        idle_inputs();
        #3;
        if (ld && !mis)      exp_stalls = 2 + gd + rd;
        else if (st && !mis) exp_stalls = (gd == 0) ? 0 : 1 + gd;
        else                 exp_stalls = 0;
        chk("stall_cycles", stalls, exp_stalls);
        chk("load_valid_one_cycle", load_valid, 1'b0);
        chk("back_to_idle", state, S_IDLE);
        if (st && !mis) begin
            chk("addr_hold", dmem_addr, a - (a % 4));
            chk("wdata_hold", dmem_wdata, m_bus(st, t, a, d).wdata);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (rst) begin
            prev_wait <= 1'b0;
        end else begin
            if (prev_wait) begin
                chk("req_held", dmem_req, 1'b1);
                chk("req_addr_stable", dmem_addr, prev_bus.addr);
                chk("req_be_stable", dmem_be, prev_bus.be);
                chk("req_wdata_stable", dmem_wdata, prev_bus.wdata);
            end
            if (dmem_req && dmem_gnt) begin
                if (bus_q.size() == 0) begin
                    chk("unexpected_request", 1'b1, 1'b0);
                end else begin
                    bus_t e;
                    e = bus_q.pop_front();
                    chk("bus_we", dmem_we, e.we);
                    chk("bus_addr", dmem_addr, e.addr);
                    chk("bus_be", dmem_be, e.be);
                    if (e.we) chk("bus_wdata", dmem_wdata, e.wdata);
                end
            end
            if (load_valid) begin
                if (exp_q.size() == 0) chk("unexpected_load_valid", 1'b1, 1'b0);
                else                   chk("load_data", load_data, exp_q.pop_front());
            end
            prev_wait <= dmem_req && !dmem_gnt;
            prev_bus  <= '{dmem_we, dmem_addr, dmem_be, dmem_wdata};
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0]  t;
        logic [31:0] a;
        logic        we;
        rst         = 1'b1;
        instr_valid = 1'b1;
        dram_we     = 1'b0;
        alu_result  = 32'h0000_0040;
        rd2         = 32'h1234_5678;
        sl_type     = T_LW;
        dmem_gnt    = 1'b1;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        #4;
        chk("reset_state", state, S_IDLE);
        chk("reset_req", dmem_req, 1'b0);
        chk("reset_stall", stall, 1'b0);
        chk("reset_load_valid", load_valid, 1'b0);
        chk("reset_load_data", load_data, 32'h0);
        chk("reset_addr", dmem_addr, 32'h0);
        chk("reset_be", dmem_be, 4'h0);
        chk("reset_wdata", dmem_wdata, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_inputs();
        #3;
        chk("post_reset_idle", state, S_IDLE);

        // LB, sign-extended top byte, minimum latency
        do_op(1'b1, 1'b0, T_LB, 32'h0000_1003, 32'h0, 32'h80FF_1234, 0, 0);
        chk("lb_data_const", load_data, 32'hFFFF_FF80);
        // LHU upper half, zero-extended
        do_op(1'b1, 1'b0, T_LHU, 32'h0000_2002, 32'h0, 32'hBEEF_0000, 0, 0);
        chk("lhu_data_const", load_data, 32'h0000_BEEF);
        // SB with immediate grant: no stall, byte replicated
        do_op(1'b1, 1'b1, T_SB, 32'h0000_0011, 32'h0000_00AB, 32'h0, 0, 0);
        chk("sb_addr_const", dmem_addr, 32'h0000_0010);
        chk("sb_be_const", dmem_be, 4'b0010);
        chk("sb_wdata_const", dmem_wdata, 32'hABAB_ABAB);
        // LW with grant withheld two cycles
        do_op(1'b1, 1'b0, T_LW, 32'h0000_0040, 32'h0, 32'hCAFE_F00D, 2, 0);
        chk("lw_data_const", load_data, 32'hCAFE_F00D);
        // Misaligned SW
        do_op(1'b1, 1'b1, T_SW, 32'h0000_0006, 32'h1111_2222, 32'h0, 0, 0);
        // SH upper half with delayed grant, LH sign extension
        do_op(1'b1, 1'b1, T_SH, 32'h0000_0102, 32'h0000_9876, 32'h0, 1, 0);
        do_op(1'b1, 1'b0, T_LH, 32'h0000_0200, 32'h0, 32'h0000_8001, 0, 2);
        chk("lh_data_const", load_data, 32'hFFFF_8001);
        // Undefined type code and store type without write-enable are no-ops
        do_op(1'b1, 1'b0, 4'd12, 32'h0000_0000, 32'h0, 32'h0, 0, 0);
        do_op(1'b1, 1'b0, T_SW, 32'h0000_0000, 32'h0, 32'h0, 0, 0);

        // Reset while waiting for read data; late rvalid must be ignored
        tick();
        instr_valid = 1'b1;
        dram_we     = 1'b0;
        sl_type     = T_LW;
        alu_result  = 32'h0000_0080;
        dmem_gnt    = 1'b1;
        bus_q.push_back(m_bus(1'b0, T_LW, 32'h0000_0080, 32'h0));
        #3;
        tick();
        idle_inputs();
        #3;
        chk("abandon_in_wait_rvalid", state, S_WAIT_RVALID);
        tick();
        rst = 1'b1;
        #3;
        chk("abandon_stall_in_reset", stall, 1'b0);
        chk("abandon_addr_in_reset", dmem_addr, 32'h0);
        tick();
        rst = 1'b0;
        #3;
        chk("abandon_state_idle", state, S_IDLE);
        tick();
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h5555_AAAA;
        #3;
        chk("abandon_rvalid_state", state, S_IDLE);
        tick();
        dmem_rvalid = 1'b0;
        #3;
        chk("abandon_no_load_valid", load_valid, 1'b0);
        chk("abandon_load_data_cleared", load_data, 32'h0);

        // Random traffic
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 4) == 0) t = 4'($urandom_range(0, 15));
            else                           t = 4'($urandom_range(1, 8));
            if (t >= T_SB && t <= T_SW) we = ($urandom_range(0, 9) != 0);
            else                        we = ($urandom_range(0, 9) == 0);
            a = $urandom;
            case ($urandom_range(0, 2))
                0: a = a;
                1: a = a & 32'hFFFF_FFFC;
                default: a = a & 32'hFFFF_FFFE;
            endcase
            do_op(1'($urandom_range(0, 7) != 0), we, t, a, $urandom, $urandom,
                  $urandom_range(0, 3), $urandom_range(0, 3));
        end

        repeat (3) tick();
        chk("bus_queue_drained", bus_q.size(), 0);
        chk("load_queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        failures++;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
